// File: rtl/rf_port_ctrl.sv
// Client-side controller for the 32x32 2R1W flop register file: clears the file after reset,
// then shares the write port and read port B between the core and a debug/loader port.
module rf_port_ctrl #(
  parameter bit BYPASS     = 1'b1,
  parameter int STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        init_done,
  output logic        core_stall,
  input  logic [4:0]  core_ra,
  input  logic [4:0]  core_rb,
  input  logic        core_rb_en,
  output logic [31:0] core_da,
  output logic [31:0] core_db,
  input  logic        core_we,
  input  logic [4:0]  core_rw,
  input  logic [31:0] core_dw,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [4:0]  rf_ra,
  output logic [4:0]  rf_rb,
  output logic [4:0]  rf_rw,
  output logic        rf_we,
  output logic [31:0] rf_dw,
  input  logic [31:0] rf_da,
  input  logic [31:0] rf_db
);

  typedef enum logic [1:0] {INIT, RUN, ACK} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [4:0]    init_cnt;
  logic [SW-1:0] starve_cnt;
  logic          core_wr;
  logic          dbg_accept;

  // A stalled core gives up both shared ports, so a forced debug access sees its own address.
  always_comb begin
    core_wr    = (state != INIT) && core_we && !core_stall;
    dbg_accept = (state == RUN) && dbg_req &&
                 (dbg_we ? (!core_we || core_stall) : (!core_rb_en || core_stall));
    rf_ra = core_ra;
    rf_rb = (core_rb_en && !core_stall) ? core_rb : dbg_addr;
    rf_we = 1'b0;
    rf_rw = core_rw;
    rf_dw = core_dw;
    if (state == INIT) begin
      rf_we = RESET_N;
      rf_rw = init_cnt;
      rf_dw = '0;
    end else if (core_wr) begin
      rf_we = 1'b1;
    end else if (dbg_accept && dbg_we) begin
      rf_we = 1'b1;
      rf_rw = dbg_addr;
      rf_dw = dbg_wdata;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign core_da = (rf_we && rf_rw == rf_ra) ? rf_dw : rf_da;
      assign core_db = (rf_we && rf_rw == rf_rb) ? rf_dw : rf_db;
    end else begin : g_direct
      assign core_da = rf_da;
      assign core_db = rf_db;
    end
  endgenerate

  // Stall is registered: it is raised for the cycle after the starve count hits its limit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= INIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      core_stall <= 1'b1;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 5'd1;
          if (init_cnt == 5'd31) begin
            state      <= RUN;
            init_done  <= 1'b1;
            core_stall <= 1'b0;
          end
        end
        RUN: begin
          if (dbg_accept) begin
            state      <= ACK;
            dbg_ack    <= 1'b1;
            starve_cnt <= '0;
            core_stall <= 1'b0;
            if (!dbg_we)
              dbg_rdata <= core_db;
          end else if (dbg_req) begin
            starve_cnt <= starve_cnt + 1'b1;
            core_stall <= (starve_cnt + 1'b1 == SW'(STARVE_MAX));
          end else begin
            starve_cnt <= '0;
            core_stall <= 1'b0;
          end
        end
        ACK: begin
          state      <= RUN;
          dbg_ack    <= 1'b0;
          core_stall <= 1'b0;
          if (!dbg_req)
            starve_cnt <= '0;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: behavioural flop register file on the rf_* ports and a
// scoreboard of expected debug completions.
module tb_rf_port_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        init_done, core_stall;
  logic [4:0]  core_ra = '0, core_rb = '0;
  logic        core_rb_en = 1'b0;
  logic [31:0] core_da, core_db;
  logic        core_we = 1'b0;
  logic [4:0]  core_rw = '0;
  logic [31:0] core_dw = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_ra, rf_rb, rf_rw;
  logic        rf_we;
  logic [31:0] rf_dw, rf_da, rf_db;

  typedef struct {
    logic        isWrite;
    logic [31:0] data;
  } dbgExp_t;

  dbgExp_t     dbgQ[$];
  logic [31:0] rfMem [32];
  int          total = 0;
  int          bad = 0;

  always #5 CLK = ~CLK;

  rf_port_ctrl #(.BYPASS(1'b1), .STARVE_MAX(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .init_done(init_done), .core_stall(core_stall),
    .core_ra(core_ra), .core_rb(core_rb), .core_rb_en(core_rb_en),
    .core_da(core_da), .core_db(core_db), .core_we(core_we), .core_rw(core_rw),
    .core_dw(core_dw), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw), .rf_we(rf_we), .rf_dw(rf_dw),
    .rf_da(rf_da), .rf_db(rf_db)
  );

  // Junk is loaded while reset is held so that the clear sequence is actually visible.
  always @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= 32'hA5A50000 | i;
    end else if (rf_we) begin
      rfMem[rf_rw] <= rf_dw;
    end
  end

  assign rf_da = rfMem[rf_ra];
  assign rf_db = rfMem[rf_rb];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    dbgQ.push_back('{we, expData});
  endtask

  task automatic waitAck(input string tag, input int expLat, input int expStallAt);
    int      n = 0;
    int      stallAt = -1;
    bit      got = 1'b0;
    dbgExp_t e;
    while (n < 40 && !got) begin
      @(negedge CLK);
      n++;
      if (core_stall && stallAt < 0) stallAt = n;
      if (dbg_ack) got = 1'b1;
    end
    checkOutput({tag, "_acked"}, 32'(got), 32'd1);
    if (got) begin
      checkOutput({tag, "_latency"}, n, expLat);
      checkOutput({tag, "_stallAt"}, stallAt, expStallAt);
      e = dbgQ.pop_front();
      if (!e.isWrite) checkOutput({tag, "_rdata"}, dbg_rdata, e.data);
      dbg_req = 1'b0;
      @(negedge CLK);
      #1;
      checkOutput({tag, "_ackOneCycle"}, 32'(dbg_ack), 32'd0);
    end else begin
      dbgQ.delete();
      dbg_req = 1'b0;
    end
  endtask

  task automatic runInit();
    for (int i = 0; i < 32; i++) begin
      checkOutput("init_we", 32'(rf_we), 32'd1);
      checkOutput("init_rw", 32'(rf_rw), i);
      checkOutput("init_dw", rf_dw, 32'd0);
      checkOutput("init_doneLow", 32'(init_done), 32'd0);
      checkOutput("init_stall", 32'(core_stall), 32'd1);
      checkOutput("init_noAck", 32'(dbg_ack), 32'd0);
      @(negedge CLK);
      #1;
    end
    checkOutput("init_done", 32'(init_done), 32'd1);
    checkOutput("run_stall", 32'(core_stall), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("rst_we", 32'(rf_we), 32'd0);
    checkOutput("rst_done", 32'(init_done), 32'd0);
    checkOutput("rst_stall", 32'(core_stall), 32'd1);
    checkOutput("rst_ack", 32'(dbg_ack), 32'd0);
    checkOutput("rst_rdata", dbg_rdata, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    runInit();
    core_ra = 5'd17;
    #1;
    checkOutput("read17_cleared", core_da, 32'd0);

    @(negedge CLK);
    core_we = 1'b1; core_rw = 5'd5; core_dw = 32'hDEADBEEF; core_ra = 5'd5;
    #1;
    checkOutput("bypass_da", core_da, 32'hDEADBEEF);
    checkOutput("bypass_rfwe", 32'(rf_we), 32'd1);
    @(negedge CLK);
    core_we = 1'b0;
    #1;
    checkOutput("after_rfda", rf_da, 32'hDEADBEEF);
    checkOutput("after_da", core_da, 32'hDEADBEEF);

    @(negedge CLK);
    applyStimulus(1'b1, 5'd9, 32'h12345678, 32'h0);
    #1;
    checkOutput("dbgwr_rw", 32'(rf_rw), 32'd9);
    checkOutput("dbgwr_dw", rf_dw, 32'h12345678);
    waitAck("dbgwr9", 1, -1);
    core_ra = 5'd9;
    #1;
    checkOutput("read9", core_da, 32'h12345678);

    @(negedge CLK);
    core_rb_en = 1'b1; core_rb = 5'd3;
    applyStimulus(1'b0, 5'd9, 32'h0, 32'h12345678);
    waitAck("starve", 9, 8);
    core_rb_en = 1'b0;

    @(negedge CLK);
    core_we = 1'b1; core_rw = 5'd20; core_dw = 32'hAAAA0001;
    applyStimulus(1'b1, 5'd21, 32'hBBBB0021, 32'h0);
    #1;
    checkOutput("contend_rw1", 32'(rf_rw), 32'd20);
    checkOutput("contend_dw1", rf_dw, 32'hAAAA0001);
    @(negedge CLK);
    core_dw = 32'hAAAA0002;
    #1;
    checkOutput("contend_noAck", 32'(dbg_ack), 32'd0);
    checkOutput("contend_rw2", 32'(rf_rw), 32'd20);
    @(negedge CLK);
    core_we = 1'b0;
    #1;
    checkOutput("contend_dbgWe", 32'(rf_we), 32'd1);
    checkOutput("contend_dbgRw", 32'(rf_rw), 32'd21);
    checkOutput("contend_dbgDw", rf_dw, 32'hBBBB0021);
    waitAck("contend", 1, -1);
    core_ra = 5'd20; core_rb_en = 1'b1; core_rb = 5'd21;
    #1;
    checkOutput("read20", core_da, 32'hAAAA0002);
    checkOutput("read21_b", core_db, 32'hBBBB0021);
    core_rb_en = 1'b0;

    @(negedge CLK);
    applyStimulus(1'b0, 5'd21, 32'h0, 32'hBBBB0021);
    waitAck("dbgrd21", 1, -1);

    @(negedge CLK);
    core_we = 1'b1; core_rw = 5'd22; core_dw = 32'hCAFEF00D;
    applyStimulus(1'b0, 5'd22, 32'h0, 32'hCAFEF00D);
    waitAck("dbgrdBypass", 1, -1);
    core_we = 1'b0;

    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    checkOutput("rst2_we", 32'(rf_we), 32'd0);
    checkOutput("rst2_done", 32'(init_done), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
    repeat (12) @(negedge CLK);
    #1;
    checkOutput("mid_rw12", 32'(rf_rw), 32'd12);
    checkOutput("mid_noAck", 32'(dbg_ack), 32'd0);
    RESET_N = 1'b0;
    #1;
    checkOutput("mid_rstWe", 32'(rf_we), 32'd0);
    checkOutput("mid_rstDone", 32'(init_done), 32'd0);
    checkOutput("mid_rstStall", 32'(core_stall), 32'd1);
    dbg_req = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    runInit();
    core_ra = 5'd9;
    #1;
    checkOutput("reclear9", core_da, 32'd0);
    core_ra = 5'd20;
    #1;
    checkOutput("reclear20", core_da, 32'd0);
    checkOutput("scoreboard_empty", dbgQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule

// File: doc/rf_port_ctrl.md
Name: rf_port_ctrl

Overview:
- Client-side controller for the 32x32 2R1W flop register file. It drives the file's RA/RB/RW/WE/DW ports and consumes its DA/DB outputs.
- After reset it zero-initialises all 32 entries.
- It then multiplexes the Hack core (primary) and a debug/loader port (secondary) onto the single write port and the B read port.
- It provides write-to-read bypass and starvation-bounded arbitration.

Parameters:
- BYPASS, 1, when 1, a read of the address being written this cycle returns the write data instead of the stale array data.
- STARVE_MAX, 8, number of consecutive cycles a pending debug request may be blocked before the core is stalled for one cycle.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- init_done  out  1  high once all 32 entries have been cleared.
- core_stall  out  1  core must not issue reads or writes this cycle.
- core_ra  in  5  core read address A.
- core_rb  in  5  core read address B.
- core_rb_en  in  1  core uses read port B this cycle.
- core_da  out  32  read data A (combinational, bypassed).
- core_db  out  32  read data B (combinational, bypassed).
- core_we  in  1  core write enable.
- core_rw  in  5  core write address.
- core_dw  in  32  core write data.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req.
- dbg_addr  in  5  debug register address.
- dbg_wdata  in  32  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  debug read data, valid while dbg_ack.
- rf_ra  out  5  to register file RA.
- rf_rb  out  5  to register file RB.
- rf_rw  out  5  to register file RW.
- rf_we  out  1  to register file WE.
- rf_dw  out  32  to register file DW.
- rf_da  in  32  from register file DA.
- rf_db  in  32  from register file DB.

Behaviour:
- Interface: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset values:
  - state=INIT, init counter=0
  - init_done=0, core_stall=1
  - dbg_ack=0, dbg_rdata=0
  - starve counter=0
  - rf_we is forced 0 while RESET_N is low.
- State machine: INIT, RUN, ACK.
- INIT:
  - rf_we=1, rf_rw=counter, rf_dw=0; counter increments each cycle.
  - On the cycle counter==31 the write completes and the next state is RUN, with init_done=1 registered.
  - The init write therefore occupies exactly 32 cycles.
  - core_stall=1 throughout. dbg_req is ignored (not acked).
- RUN, read ports:
  - rf_ra=core_ra always.
  - rf_rb=core_rb when core_rb_en=1, else dbg_addr.
- RUN, write port:
  - If core_we=1 and core_stall=0, the core write goes to the file: rf_we=1, rf_rw=core_rw, rf_dw=core_dw.
  - Otherwise a pending debug write is issued: rf_we=1, rf_rw=dbg_addr, rf_dw=dbg_wdata.
- Debug acceptance in RUN:
  - A debug read is accepted when core_rb_en=0 or core_stall=1.
  - A debug write is accepted when core_we=0 or core_stall=1.
  - On acceptance, dbg_rdata captures the bypassed B data (reads only; it holds its value on writes). The next state is ACK with dbg_ack=1 registered.
- ACK: lasts exactly one cycle with dbg_ack=1. No debug acceptance occurs. Core traffic proceeds normally. Next state is RUN.
  - If dbg_req is still high in RUN, it is treated as a new request.
- Starvation:
  - The starve counter increments each RUN cycle in which dbg_req=1 and the request is not accepted. It clears on acceptance or when dbg_req=0.
  - When the counter reaches STARVE_MAX, core_stall=1 for the following single cycle and the debug request is accepted in that cycle.
  - The counter then clears. core_stall=0 otherwise in RUN and ACK.
- Bypass (BYPASS=1):
  - core_da = (rf_we && rf_rw==core_ra) ? rf_dw : rf_da.
  - core_db and the debug read path follow the same rule against rf_rb.
  - With BYPASS=0, rf_da and rf_db pass straight through.
- Core reads are combinational, so read data is valid in the same cycle.
- Reset mid-operation: any RESET_N low returns to INIT immediately, clears init_done, and restarts the full 32-entry clear. A pending debug transaction is dropped without ack.

Test Plan:
- Reset release → rf_we=1 with rf_rw stepping 0..31 for 32 cycles, rf_dw=0; init_done rises on the next edge; a core read of reg 17 then returns 0.
- core_we=1, rw=5, dw=0xDEADBEEF with ra=5 in the same cycle → core_da=0xDEADBEEF that cycle (bypass); next cycle rf_da=0xDEADBEEF.
- Debug write addr 9 = 0x12345678 while core idle → dbg_ack one cycle later; core read of reg 9 returns 0x12345678.
- core_rb_en=1 continuously, debug read pending → blocked 8 cycles; core_stall=1 on the 9th; debug read accepted; dbg_ack next cycle with correct data.
- RESET_N pulsed low at init count 12 → counter restarts at 0, init_done stays 0, full 32-cycle clear repeats.
- Debug write and core write same cycle, core_stall=0 → core write wins; debug write lands later, dbg_ack only after it completes.
